// File: rtl/function_pkg.sv
// Shared definitions for the function-block sweep checker.
//   VEC_W    : width of one {x,y,z} input vector
//   NUM_VEC  : number of input vectors in a full sweep
//   GOLDEN_F : truth table of f = x | (~y & z), bit i = f for vector i = {x,y,z}
//   LAST_VEC : index of the final vector of a sweep
//   state_e  : checker FSM states
package function_pkg;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned NUM_VEC = 8;

    localparam logic [NUM_VEC-1:0] GOLDEN_F = 8'hF2;
    localparam logic [VEC_W-1:0]   LAST_VEC = VEC_W'(NUM_VEC - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSweep
    } state_e;

endpackage

// File: rtl/function_checker.sv
// Self-checking sweep engine for a 3-input combinational function block.
// On an accepted start it drives all eight {x,y,z} vectors in ascending order. Each vector
// is held for SETTLE cycles, then f is sampled and compared against TRUTH[vector].
//
// Parameters:
//   TRUTH  : golden f per vector index {x,y,z}
//   SETTLE : cycles each vector is held before f is sampled (must be >= 1)
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a sweep, accepted only when idle
//   f          : output of the block under test, sampled without a synchronizer
//   x, y, z    : registered drive to the block under test
//   busy       : high while a sweep is in progress
//   done       : one-cycle pulse when a sweep completes
//   pass       : last completed sweep had no mismatches
//   err_count  : mismatches in the last or current sweep (0..8)
//   first_fail : lowest-index failing vector
//   fail_valid : first_fail holds a valid value
module function_checker
    import function_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] TRUTH  = GOLDEN_F,
    parameter int unsigned        SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             f,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_valid
);

    localparam int unsigned      CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       err_q, err_d;
    logic [VEC_W-1:0] first_q, first_d;
    logic             fvalid_q, fvalid_d;

    logic             mismatch;
    logic [3:0]       err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            vec_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            first_q  <= first_d;
            fvalid_q <= fvalid_d;
        end
    end

    // Mismatch count including the vector being sampled this cycle; at most 8 per sweep,
    // so the 4-bit counter cannot wrap.
    assign mismatch = (f != TRUTH[vec_q]);
    assign err_inc  = err_q + {3'b000, mismatch};

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        first_d  = first_q;
        fvalid_d = fvalid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StSweep;
                    vec_d    = '0;
                    cnt_d    = CNT_LOAD;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    first_d  = '0;
                    fvalid_d = 1'b0;
                end
            end
            StSweep: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    err_d = err_inc;
                    if (mismatch && !fvalid_q) begin
                        first_d  = vec_q;
                        fvalid_d = 1'b1;
                    end
                    if (vec_q != LAST_VEC) begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = CNT_LOAD;
                    end else begin
                        // vec_q stays at 3'b111 so x,y,z hold the last vector while idle.
                        state_d = StIdle;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == '0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The vector register doubles as the x,y,z drive register.
    assign {x, y, z}  = vec_q;
    assign busy       = (state_q == StSweep);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = first_q;
    assign fail_valid = fvalid_q;

endmodule

// File: tb/tb_function_checker.sv
// Bench for function_checker: a SETTLE=2 instance fed by either the real function block or
// an arbitrary table-driven block, plus a SETTLE=1 instance for back-to-back sweeps.
module tb_function_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // SETTLE = 2 instance
    logic       start = 1'b0;
    logic       f;
    logic       x, y, z, busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] first_fail;
    logic       use_expr = 1'b1;
    logic [7:0] blk_tbl  = 8'h00;

    assign f = use_expr ? (x | (~y & z)) : blk_tbl[{x, y, z}];

    function_checker #(.SETTLE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .f          (f),
        .x          (x),
        .y          (y),
        .z          (z),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_valid (fail_valid)
    );

    // SETTLE = 1 instance
    logic       start1 = 1'b0;
    logic       f1;
    logic       x1, y1, z1, busy1, done1, pass1, fail_valid1;
    logic [3:0] err_count1;
    logic [2:0] first_fail1;
    logic [7:0] tbl1 = 8'h00;

    assign f1 = tbl1[{x1, y1, z1}];

    function_checker #(.SETTLE(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .f          (f1),
        .x          (x1),
        .y          (y1),
        .z          (z1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .err_count  (err_count1),
        .first_fail (first_fail1),
        .fail_valid (fail_valid1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: f = x | (~y & z) evaluated per vector index {x,y,z}.
    function automatic logic ref_f(input int i);
        logic [2:0] v;
        v = i[2:0];
        return v[2] | (~v[1] & v[0]);
    endfunction

    function automatic int model_errs(input logic [7:0] tbl);
        int n = 0;
        for (int i = 0; i < 8; i++) if (tbl[i] != ref_f(i)) n++;
        return n;
    endfunction

    function automatic int model_first(input logic [7:0] tbl);
        for (int i = 0; i < 8; i++) if (tbl[i] != ref_f(i)) return i;
        return -1;
    endfunction

    // Pulse start for one edge (E0) and wait for done; lat = edges after E0 until done seen.
    task automatic do_sweep(output int lat, output logic [2:0] xyz0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        xyz0  = {x, y, z};
        start = 1'b0;
        lat   = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({x, y, z, busy, done, pass, err_count, first_fail, fail_valid} !== 14'd0)
            $display("FAIL reset_dut: got %b want all zero",
                     {x, y, z, busy, done, pass, err_count, first_fail, fail_valid});
        else n_pass++;
        n_checks++;
        if ({x1, y1, z1, busy1, done1, pass1, err_count1, first_fail1, fail_valid1} !== 14'd0)
            $display("FAIL reset_dut1: got %b want all zero",
                     {x1, y1, z1, busy1, done1, pass1, err_count1, first_fail1, fail_valid1});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Full sweep against a given f table (or the real block) with latency and result checks.
    task automatic run_and_check(input string name, input logic expr, input logic [7:0] tbl);
        int         lat;
        logic [2:0] xyz0;
        int         e;
        int         ff;
        logic [8:0] exp_res;
        use_expr = expr;
        blk_tbl  = tbl;
        e  = expr ? 0 : model_errs(tbl);
        ff = expr ? -1 : model_first(tbl);
        exp_res = {(e == 0), 4'(e), (ff >= 0), (ff >= 0) ? 3'(ff) : 3'd0};
        do_sweep(lat, xyz0);
        n_checks++;
        if (xyz0 !== 3'b000) $display("FAIL %s_vec0: xyz %b want 000", name, xyz0);
        else n_pass++;
        n_checks++;
        if (lat !== 16) $display("FAIL %s_latency: done after %0d edges want 16", name, lat);
        else n_pass++;
        n_checks++;
        if ({pass, err_count, fail_valid, first_fail} !== exp_res)
            $display("FAIL %s_result: pass/err/fv/ff %b want %b", name,
                     {pass, err_count, fail_valid, first_fail}, exp_res);
        else n_pass++;
        n_checks++;
        if ({busy, x, y, z} !== 4'b0111)
            $display("FAIL %s_idle: busy,xyz %b want 0111", name, {busy, x, y, z});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, pass, err_count} !== {1'b0, exp_res[8:4]})
            $display("FAIL %s_hold: done,pass,err %b want %b", name, {done, pass, err_count},
                     {1'b0, exp_res[8:4]});
        else n_pass++;
    endtask

    task automatic test_correct_block();
        run_and_check("correct", 1'b1, 8'h00);
    endtask

    task automatic test_tied_outputs();
        run_and_check("tied0", 1'b0, 8'h00);
        n_checks++;
        if ({err_count, first_fail} !== {4'd5, 3'd1})
            $display("FAIL tied0_exact: err,ff %0d,%0d want 5,1", err_count, first_fail);
        else n_pass++;
        run_and_check("tied1", 1'b0, 8'hFF);
        n_checks++;
        if ({err_count, first_fail, fail_valid} !== {4'd3, 3'd0, 1'b1})
            $display("FAIL tied1_exact: err,ff,fv %0d,%0d,%0d want 3,0,1", err_count,
                     first_fail, fail_valid);
        else n_pass++;
    endtask

    task automatic test_random_blocks();
        for (int it = 0; it < 6; it++) run_and_check("random", 1'b0, 8'($urandom));
        run_and_check("all_wrong", 1'b0, 8'h0D);
    endtask

    task automatic test_ignored_start();
        int n_done = 0;
        int at     = -1;
        use_expr = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            start = (k == 5 || k == 9);
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                at = k;
            end
        end
        start = 1'b0;
        n_checks++;
        if (n_done !== 1 || at !== 16)
            $display("FAIL ignored_start: %0d done pulses last at %0d want 1 at 16", n_done, at);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int         n_done = 0;
        int         lat;
        logic [2:0] xyz0;
        use_expr = 1'b0;
        blk_tbl  = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, err_count, fail_valid, first_fail, x, y, z} !== {1'b1, 4'd1, 1'b1, 3'd1, 3'd3})
            $display("FAIL pre_reset: busy/err/fv/ff/xyz %b want %b",
                     {busy, err_count, fail_valid, first_fail, x, y, z},
                     {1'b1, 4'd1, 1'b1, 3'd1, 3'd3});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({x, y, z, busy, done, pass, err_count, first_fail, fail_valid} !== 14'd0)
            $display("FAIL async_reset: got %b want all zero",
                     {x, y, z, busy, done, pass, err_count, first_fail, fail_valid});
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) $display("FAIL reset_no_done: %0d done pulses want 0", n_done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        use_expr = 1'b1;
        do_sweep(lat, xyz0);
        n_checks++;
        if (lat !== 16 || {pass, err_count, fail_valid} !== {1'b1, 4'd0, 1'b0})
            $display("FAIL after_reset: lat %0d pass/err/fv %b want 16 and 1_0000_0", lat,
                     {pass, err_count, fail_valid});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int last   = -1;
        int n_done = 0;
        int bad    = 0;
        tbl1 = 8'h00;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) begin
                n_checks++;
                if ({busy1, err_count1, fail_valid1} !== {1'b1, 4'd0, 1'b0})
                    $display("FAIL b2b_restart_clear: busy/err/fv %b want 1_0000_0",
                             {busy1, err_count1, fail_valid1});
                else n_pass++;
            end
            if (done1) begin
                n_done++;
                if (last < 0 ? (k != 8) : (k - last != 9)) bad++;
                if ({pass1, err_count1, first_fail1} !== {1'b0, 4'd5, 3'd1}) bad++;
                last = k;
            end
        end
        start1 = 1'b0;
        n_checks++;
        if (n_done !== 6 || bad !== 0)
            $display("FAIL back_to_back: %0d dones, %0d bad want 6 dones, 0 bad", n_done, bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_correct_block();
        test_tied_outputs();
        test_random_blocks();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
